multi_envelope_collector: RTL and testbench
===========================================

Name: multi_envelope_collector

Overview:
- Parametrised successor to the single-sensor TS4231 envelope timer.
- Takes DDR-sampled E lines from NUM_CH sensors, already registered by the SB_IO wrappers.
- Timestamps each envelope's falling and rising edges at half-clock resolution, computes its length, and drops glitches shorter than MIN_LEN.
- Buffers events per channel and merges them round-robin onto a single valid/ready stream toward the host FIFO.

Parameters:
- NUM_CH, 4: number of sensor channels (1..8).
- ID_W, 3: width of the sensor ID field (must satisfy 2^ID_W >= NUM_CH).
- TS_W, 28: width of time_ctr.
- LEN_W, 16: width of the reported length.
- MIN_LEN, 4: minimum accepted length, in half-clock units.
- FIFO_AW, 2: per-channel buffer depth = 2^FIFO_AW entries.
- MAX_LEN, 16'hF000: timeout limit in half-clock units (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  NUM_CH  per-channel run enable (sensor configured)
- e_in  in  NUM_CH  E sample, first half of cycle
- e_in_1  in  NUM_CH  E sample, second half of cycle
- time_ctr  in  TS_W  free-running time base
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts event
- out_sensor  out  ID_W  channel index of the event
- out_timestamp  out  TS_W+1  start time, {time_ctr, half}
- out_length  out  LEN_W  envelope length, in half-clock units
- overflow  out  NUM_CH  sticky per-channel buffer overflow flag
- overflow_clr  in  NUM_CH  per-channel overflow clear pulse

Behaviour:
- Reset values: all outputs 0; all buffers empty; every channel in IDLE; previous-sample registers = 2'b11; round-robin pointer = channel 0.
- Sample pair per channel: cur = {e_in, e_in_1}. E is active-low and idles high.
- Per-channel state machine, advanced only while enable[i] = 1. Deasserting enable returns the channel to IDLE with no event emitted.
- IDLE:
  - cur = 11: stay.
  - cur = 00: start_ts = {time_ctr, 0}; go to ENV.
  - cur = 01: emit a length-1 event at start_ts = {time_ctr, 0}; stay in IDLE.
  - cur = 10: start_ts = {time_ctr, 1}; go to ENV.
- ENV:
  - cur = 00: stay.
  - cur = 11: stop_ts = {time_ctr, 0}; emit; go to IDLE.
  - cur = 01: stop_ts = {time_ctr, 1}; emit; go to IDLE.
  - cur = 10: stop_ts = {time_ctr, 0}; emit; new start_ts = {time_ctr, 1}; stay in ENV.
- Length arithmetic:
  - Computed modulo 2^(TS_W+1), so time_ctr wrap-around is transparent.
  - If the result exceeds 2^LEN_W - 1, saturate to all ones.
- Filter: any event with length < MIN_LEN is silently discarded and is not counted as overflow.
- Buffering:
  - Each emitted event is pushed into its channel buffer on the cycle after detection.
  - Buffer full at push time: the event is dropped and overflow[i] is set.
  - Exception: if that channel's buffer is popped in the same cycle, the push is accepted.
- overflow_clr[i] clears overflow[i]. A simultaneous set wins over the clear.
- Arbiter:
  - When the output register is empty, or is being consumed (out_valid & out_ready), select the first non-empty buffer starting at the channel after the last grant.
  - Pop it and load the output register.
  - The pointer advances only on a grant.
- Output handshake:
  - Fields stay stable while out_valid = 1 and out_ready = 0.
  - Back-to-back transfers run at one event per cycle.
- Latency: from the edge-sample cycle N, out_valid rises at N+2 at the earliest (buffer and output stage empty).
- Asynchronous reset mid-envelope discards all in-flight and buffered events. After release, a low sample is treated as a fresh start.

Optional Feature:
- Macro: ENVELOPE_TIMEOUT_EN.
- Defined:
  - In ENV, if ({time_ctr, 1} - start_ts) >= MAX_LEN, abort the envelope and emit nothing.
  - Go to state BLOCKED, which leaves only when cur = 11 (then to IDLE). This handles a stuck-low or unconfigured sensor.
- Undefined:
  - No BLOCKED state; ENV persists indefinitely.
  - The eventual length saturates per the length arithmetic rule.

Test Plan:
- Single envelope on ch0:
  - Stimulus: at time_ctr = 100, cur = 10; at time_ctr = 150, cur = 01.
  - Expected: one event, sensor 0, timestamp 201, length 100.
- Glitch filter: MIN_LEN = 4, 1-cycle low pulse giving length 2 -> no out_valid, overflow stays 0.
- Arbitration:
  - Stimulus: simultaneous events on ch1, ch2, ch3 with out_ready held at 1.
  - Expected: outputs in order 1, 2, 3. A following ch1 event is served after ch3's.
- Back-pressure and overflow:
  - Stimulus: out_ready = 0, FIFO_AW = 2, six events on ch2.
  - Expected:
    - out_valid held with stable data.
    - Output register plus 4-entry buffer retain the first 5 events; the 6th sets overflow[2].
    - overflow_clr[2] clears the flag.
- Wrap-around: start at time_ctr = 2^28 - 2, stop at time_ctr = 3 -> length 10, timestamp correct.
- With ENVELOPE_TIMEOUT_EN:
  - Stimulus: E held low for MAX_LEN + 10 half-cycles, then released.
  - Expected: no event. The next normal envelope reports correctly.

Source files
------------

// File: rtl/multi_envelope_collector.sv
// multi_envelope_collector: DDR envelope timer for NUM_CH sensors with per-channel FIFOs and a round-robin merge.
// Ports: clk, rst_n (async, active low); enable/e_in/e_in_1 per channel; time_ctr free-running time base;
//   out_valid/out_ready/out_sensor/out_timestamp/out_length event stream; overflow/overflow_clr sticky drop flags.
// Define ENVELOPE_TIMEOUT_EN to abort envelopes of MAX_LEN half-clocks or more and park the channel until E returns high.
module multi_envelope_collector #(
  parameter int NUM_CH = 4,
  parameter int ID_W = 3,
  parameter int TS_W = 28,
  parameter int LEN_W = 16,
  parameter int MIN_LEN = 4,
  parameter int FIFO_AW = 2
`ifdef ENVELOPE_TIMEOUT_EN
  ,
  parameter int MAX_LEN = 32'hF000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] e_in,
  input  logic [NUM_CH-1:0] e_in_1,
  input  logic [TS_W-1:0]   time_ctr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_sensor,
  output logic [TS_W:0]     out_timestamp,
  output logic [LEN_W-1:0]  out_length,
  output logic [NUM_CH-1:0] overflow,
  input  logic [NUM_CH-1:0] overflow_clr
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENV = 2'd1;
`ifdef ENVELOPE_TIMEOUT_EN
  localparam logic [1:0] BLOCKED = 2'd2;
  logic [TS_W:0] el;
`endif
  logic [1:0] state [NUM_CH];
  logic [1:0] state_n [NUM_CH];
  logic [TS_W:0] start [NUM_CH];
  logic [TS_W:0] start_n [NUM_CH];
  logic [TS_W:0] ev_ts [NUM_CH];
  logic [LEN_W-1:0] ev_len [NUM_CH];
  logic [FIFO_AW:0] wr [NUM_CH];
  logic [FIFO_AW:0] rd [NUM_CH];
  logic [TS_W+LEN_W:0] mem [NUM_CH][DEPTH];
  logic [NUM_CH-1:0] push, pop, acc, empty, full, rot;
  logic [TS_W:0] ts0, ts1, stop, diff;
  logic [TS_W+LEN_W:0] rd_data;
  logic [ID_W-1:0] ptr, gnt;
  logic [1:0] cur;
  logic emit, load;
  int k1, s;
  assign ts0 = {time_ctr, 1'b0};
  assign ts1 = {time_ctr, 1'b1};
  assign load = !out_valid || out_ready;
  // a full buffer still takes the push when its head leaves in the same cycle
  assign acc = push & (~full | pop);
  always_comb begin
    cur = 2'b11;
    emit = 1'b0;
    stop = ts0;
    diff = '0;
`ifdef ENVELOPE_TIMEOUT_EN
    el = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      state_n[i] = state[i];
      start_n[i] = start[i];
      ev_ts[i] = start[i];
      emit = 1'b0;
      stop = ts0;
      cur = {e_in[i], e_in_1[i]};
`ifdef ENVELOPE_TIMEOUT_EN
      el = ts1 - start[i];
`endif
      if (!enable[i]) state_n[i] = IDLE;
      else if (state[i] == IDLE) begin
        if (cur == 2'b00) begin
          start_n[i] = ts0;
          state_n[i] = ENV;
        end else if (cur == 2'b10) begin
          start_n[i] = ts1;
          state_n[i] = ENV;
        end else if (cur == 2'b01) begin
          emit = 1'b1;
          ev_ts[i] = ts0;
          stop = ts1;
        end
      end else if (state[i] == ENV) begin
`ifdef ENVELOPE_TIMEOUT_EN
        if (el >= (TS_W+1)'(MAX_LEN)) state_n[i] = BLOCKED;
        else
`endif
        if (cur == 2'b11) begin
          emit = 1'b1;
          state_n[i] = IDLE;
        end else if (cur == 2'b01) begin
          emit = 1'b1;
          stop = ts1;
          state_n[i] = IDLE;
        end else if (cur == 2'b10) begin
          emit = 1'b1;
          start_n[i] = ts1;
        end
      end
`ifdef ENVELOPE_TIMEOUT_EN
      else if (cur == 2'b11) state_n[i] = IDLE;
`endif
      // modulo subtraction makes time_ctr wrap transparent
      diff = stop - ev_ts[i];
      ev_len[i] = |diff[TS_W:LEN_W] ? '1 : diff[LEN_W-1:0];
      push[i] = emit && ev_len[i] >= LEN_W'(MIN_LEN);
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = wr[i] == rd[i];
      full[i] = wr[i] == (rd[i] ^ (FIFO_AW+1)'(DEPTH));
    end
    // rotate the non-empty mask so bit 0 is the channel after the last grant
    rot = NUM_CH'({~empty, ~empty} >> (int'(ptr) + 1));
    k1 = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) if (rot[k]) k1 = k;
    s = int'(ptr) + 1 + k1;
    gnt = ID_W'(s >= NUM_CH ? s - NUM_CH : s);
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = load && |rot && gnt == ID_W'(i);
      if (pop[i]) rd_data = mem[i][rd[i][FIFO_AW-1:0]];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        start[i] <= '0;
        wr[i] <= '0;
        rd[i] <= '0;
      end
      overflow <= '0;
      out_valid <= 1'b0;
      out_sensor <= '0;
      out_timestamp <= '0;
      out_length <= '0;
      ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_n[i];
        start[i] <= start_n[i];
        if (acc[i]) wr[i] <= wr[i] + (FIFO_AW+1)'(1);
        if (pop[i]) rd[i] <= rd[i] + (FIFO_AW+1)'(1);
      end
      overflow <= (overflow & ~overflow_clr) | (push & ~acc);
      if (load) out_valid <= |rot;
      if (load && |rot) begin
        ptr <= gnt;
        out_sensor <= gnt;
        {out_timestamp, out_length} <= rd_data;
      end
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (acc[i]) mem[i][wr[i][FIFO_AW-1:0]] <= {ev_ts[i], ev_len[i]};
endmodule

// File: tb/tb_multi_envelope_collector.sv
// tb_multi_envelope_collector: scoreboard bench for multi_envelope_collector with directed envelopes.
module tb_multi_envelope_collector;
  logic clk, rst_n, out_valid, out_ready;
  logic [3:0] enable, e_in, e_in_1, overflow, overflow_clr;
  logic [27:0] time_ctr;
  logic [2:0] out_sensor;
  logic [28:0] out_timestamp;
  logic [15:0] out_length;
  logic [47:0] exp_q[$];
  logic [47:0] hold, e;
  logic stall;
  int checks, errors;
  multi_envelope_collector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .e_in(e_in), .e_in_1(e_in_1),
    .time_ctr(time_ctr), .out_valid(out_valid), .out_ready(out_ready),
    .out_sensor(out_sensor), .out_timestamp(out_timestamp), .out_length(out_length),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, b);
    end
  endtask
  task automatic cycm(input logic [3:0] m, input logic [1:0] cur, input logic [27:0] t);
    for (int c = 0; c < 4; c++) begin
      e_in[c] = m[c] ? cur[1] : 1'b1;
      e_in_1[c] = m[c] ? cur[0] : 1'b1;
    end
    time_ctr = t;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycm(4'd0, 2'b11, 28'd0);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_sensor, out_timestamp, out_length}, hold);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", {out_sensor, out_timestamp, out_length});
        end else begin
          e = exp_q.pop_front();
          chk("event", {out_sensor, out_timestamp, out_length}, e);
        end
      end
      stall = out_valid && !out_ready;
      hold = {out_sensor, out_timestamp, out_length};
    end
  end
  initial begin
    checks = 0;
    errors = 0;
    stall = 1'b0;
    hold = '0;
    rst_n = 1'b0;
    enable = 4'h0;
    e_in = 4'hF;
    e_in_1 = 4'hF;
    time_ctr = '0;
    overflow_clr = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sensor", out_sensor, 0);
    chk("rst_ts", out_timestamp, 0);
    chk("rst_len", out_length, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    enable = 4'hF;
    idle(2);
    // single envelope on ch0, with latency check
    cycm(4'b0001, 2'b10, 28'd100);
    for (int t = 101; t < 150; t++) cycm(4'b0001, 2'b00, 28'(t));
    exp_q.push_back({3'd0, 29'd201, 16'd100});
    cycm(4'b0001, 2'b01, 28'd150);
    chk("lat_n1", out_valid, 0);
    cycm(4'd0, 2'b11, 28'd151);
    chk("lat_n2", out_valid, 1);
    idle(3);
    // glitch of length 2 is dropped
    cycm(4'b0001, 2'b00, 28'd200);
    cycm(4'b0001, 2'b11, 28'd201);
    idle(4);
    chk("glitch_valid", out_valid, 0);
    chk("glitch_ovf", overflow, 0);
    // arbitration 1,2,3 then a late ch1
    cycm(4'b1110, 2'b00, 28'd300);
    exp_q.push_back({3'd1, 29'd600, 16'd6});
    exp_q.push_back({3'd2, 29'd600, 16'd6});
    exp_q.push_back({3'd3, 29'd600, 16'd6});
    cycm(4'b1110, 2'b11, 28'd303);
    cycm(4'b0010, 2'b00, 28'd310);
    exp_q.push_back({3'd1, 29'd620, 16'd4});
    cycm(4'b0010, 2'b11, 28'd312);
    idle(6);
    // back-pressure and overflow on ch2
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) exp_q.push_back({3'd2, 29'(2 * (700 + 10 * k)), 16'd4});
      cycm(4'b0100, 2'b00, 28'(700 + 10 * k));
      cycm(4'b0100, 2'b11, 28'(702 + 10 * k));
    end
    idle(1);
    chk("bp_valid", out_valid, 1);
    chk("ovf_set", overflow, 4'b0100);
    overflow_clr = 4'b0100;
    idle(1);
    overflow_clr = 4'b0000;
    chk("ovf_clr", overflow, 0);
    out_ready = 1'b1;
    idle(8);
    // saturation of an over-long envelope on ch1
    cycm(4'b0010, 2'b10, 28'd1000);
    exp_q.push_back({3'd1, 29'd2001, 16'hFFFF});
    cycm(4'b0010, 2'b01, 28'd41000);
    idle(4);
    // dropping enable abandons the envelope on ch3
    cycm(4'b1000, 2'b00, 28'd400);
    enable = 4'b0111;
    cycm(4'b1000, 2'b00, 28'd401);
    enable = 4'hF;
    cycm(4'b1000, 2'b11, 28'd405);
    idle(4);
    // async reset mid-envelope on ch0
    cycm(4'b0001, 2'b00, 28'd600);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", out_valid, 0);
    rst_n = 1'b1;
    cycm(4'b0001, 2'b11, 28'd602);
    idle(4);
    // time_ctr wrap-around
    cycm(4'b0001, 2'b00, 28'hFFFFFFE);
    exp_q.push_back({3'd0, 29'h1FFFFFFC, 16'd10});
    cycm(4'b0001, 2'b11, 28'd3);
    idle(3);
    // 10 in ENV closes one envelope and opens the next
    cycm(4'b0001, 2'b00, 28'd500);
    exp_q.push_back({3'd0, 29'd1000, 16'd6});
    cycm(4'b0001, 2'b10, 28'd503);
    exp_q.push_back({3'd0, 29'd1007, 16'd14});
    cycm(4'b0001, 2'b01, 28'd510);
    for (int w = 0; w < 50 && exp_q.size() > 0; w++) idle(1);
    idle(3);
    chk("drained", exp_q.size(), 0);
    chk("final_ovf", overflow, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
